mux_rr_stream: RTL
==================

MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 Parameter WIDTH, default 32, data bits per channel (>=1).
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SW, default 2, select width; SHALL equal max(1, ceil(log2 N)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clrn  input  1  asynchronous active-low reset (clear).
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel i has a beat offered.
REQ-008 in_ready  output  N  channel i beat accepted this cycle when in_valid[i] and in_ready[i] are both high.
REQ-009 out_data  output  WIDTH  registered output beat.
REQ-010 out_valid  output  1  out_data holds an undelivered beat.
REQ-011 out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
REQ-012 out_sel  output  SW  registered index of the channel that supplied out_data.

Function
REQ-013 Output stage: one register slot (out_data, out_sel, out_valid); load = !out_valid || out_ready.
REQ-014 Grant: combinational round-robin search starting at pointer ptr, ascending modulo N, first i with in_valid[i]=1.
REQ-015 in_ready[i] = load && (i == grant) && any in_valid; at most one in_ready bit high per cycle.
REQ-016 On accept from channel g: out_data <= channel g data, out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N.
REQ-017 Latency: a beat accepted in cycle t appears on out_data with out_valid=1 in cycle t+1.
REQ-018 Throughput: one beat per cycle sustained while out_ready=1 continuously.
REQ-019 Delivery with no accept in the same cycle: out_valid <= 0; out_data and out_sel hold their values.
REQ-020 Stall: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL not change, and in_ready SHALL be all zero.
REQ-021 Simultaneous delivery and accept: the new beat replaces the old one in the same edge, with no bubble.
REQ-022 No input valid: ptr holds.
REQ-023 ptr wraps from N-1 to 0; for non-power-of-two N, ptr SHALL never hold a value >= N.
REQ-024 Fairness: with all channels continuously valid, grants SHALL cycle 0,1,...,N-1,0,...
REQ-025 in_ready SHALL not depend combinationally on in_data.

Reset
REQ-026 clrn low: out_valid=0, out_data=0, out_sel=0, ptr=0 immediately, independent of clk.
REQ-027 in_ready SHALL be all zero while clrn is low.
REQ-028 Reset asserted mid-transfer discards the held beat, and no beat is delivered after release until a new accept.
REQ-029 First accept after reset release SHALL occur no earlier than the first rising edge with clrn high.

Configuration
REQ-030 Macro MUX_RR_PKT_LOCK_EN: when defined, adds input in_last [N] and output out_last [1]; out_last is registered alongside out_data.
REQ-031 With the macro, once channel g is granted, the grant SHALL stay locked to g until a beat with in_last[g]=1 is accepted; ptr then advances to (g+1) mod N.
REQ-032 With the macro, channel g deasserting in_valid mid-packet SHALL not release the lock.
REQ-033 Without the macro, the in_last and out_last ports SHALL be absent and arbitration is per beat (REQ-014..REQ-024).

Verification
REQ-034 Reset: clrn=0 with random inputs -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
REQ-035 N=4, all in_valid=1, out_ready=1, in_data[i]=0x100+i -> out_sel 0,1,2,3,0,... one per cycle; out_data 0x100,0x101,...
REQ-036 Only ch2 valid, data 0xCAFE; out_ready=0 for 3 cycles -> out_data=0xCAFE stable, out_valid=1, in_ready=0; 0xCAFE delivered once when out_ready=1.
REQ-037 N=3, ch2 then ch0 valid -> ptr wraps 2->0; grant sequence 2,0.
REQ-038 clrn pulsed low while out_valid=1 holding 0x55 -> out_valid=0 at once; 0x55 never delivered.
REQ-039 MUX_RR_PKT_LOCK_EN defined: ch1 sends a 3-beat packet (last on beat 3), ch0 continuously valid -> out_sel 1,1,1 then 0.

Source files
------------

// File: rtl/mux_rr_stream.sv
// N-to-1 round-robin stream multiplexer with a single registered output slot.
// Optional packet locking (in_last/out_last) is enabled by defining MUX_RR_PKT_LOCK_EN.
module mux_rr_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SW    = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_sel
`ifdef MUX_RR_PKT_LOCK_EN
  ,
  input  logic [N-1:0]       in_last,
  output logic               out_last
`endif
);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    rr_grant;
  logic             rr_valid;
  logic [SW-1:0]    grant;
  logic             grant_valid;
  logic [SW-1:0]    grant_next;
  logic [WIDTH-1:0] sel_data;
  logic             load;
  logic             accept;

`ifdef MUX_RR_PKT_LOCK_EN
  typedef enum logic {ARB, LOCKED} lock_state_t;
  lock_state_t   lock_state;
  logic [SW-1:0] lock_ch;
  logic          sel_last;
`endif

  // Two ascending passes (indices >= ptr, then < ptr) give the modulo-N search
  // without ever forming an out-of-range index for non-power-of-two N.
  always_comb begin
    rr_grant = ptr;
    rr_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!rr_valid && in_valid[i] && (i >= 32'(ptr))) begin
        rr_valid = 1'b1;
        rr_grant = SW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!rr_valid && in_valid[i] && (i < 32'(ptr))) begin
        rr_valid = 1'b1;
        rr_grant = SW'(i);
      end
    end
  end

  always_comb begin
    grant       = rr_grant;
    grant_valid = rr_valid;
`ifdef MUX_RR_PKT_LOCK_EN
    // Mid-packet the grant is pinned to the locked channel even if it idles.
    if (lock_state == LOCKED) begin
      grant       = lock_ch;
      grant_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        if (lock_ch == SW'(i)) grant_valid = in_valid[i];
      end
    end
`endif
  end

  always_comb begin
    sel_data = '0;
`ifdef MUX_RR_PKT_LOCK_EN
    sel_last = 1'b0;
`endif
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_RR_PKT_LOCK_EN
        sel_last = in_last[i];
`endif
      end
    end
  end

  assign grant_next = (grant == SW'(N-1)) ? '0 : grant + SW'(1);
  assign load       = !out_valid || out_ready;
  assign accept     = load && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = clrn && accept && (grant == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      ptr        <= '0;
`ifdef MUX_RR_PKT_LOCK_EN
      out_last   <= 1'b0;
      lock_state <= ARB;
      lock_ch    <= '0;
`endif
    end else if (load) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant;
`ifdef MUX_RR_PKT_LOCK_EN
        out_last  <= sel_last;
        if (sel_last) begin
          lock_state <= ARB;
          ptr        <= grant_next;
        end else begin
          lock_state <= LOCKED;
          lock_ch    <= grant;
        end
`else
        ptr       <= grant_next;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
